// File: rtl/mem_ctrl_pkg.sv
// Shared CPU-side constants: register/address widths, stall levels and memory width codes,
// plus the small transaction descriptor the memory controller latches on acceptance.
package mem_ctrl_pkg;

    localparam int AddrLen       = 32;
    localparam int RegLen        = 32;
    localparam int RegNum        = 32;
    localparam int RegAddrLen    = 5;

    // One stall bit per pipeline level, PC first.
    localparam int StallLevelLen = 6;
    localparam int StallPc       = 0;
    localparam int StallIf       = 1;
    localparam int StallId       = 2;
    localparam int StallEx       = 3;
    localparam int StallMem      = 4;
    localparam int StallWb       = 5;

    localparam logic [1:0] MemByte = 2'b00;
    localparam logic [1:0] MemHalf = 2'b01;
    localparam logic [1:0] MemWord = 2'b10;

    typedef enum logic {
        SrcIf  = 1'b0,
        SrcMem = 1'b1
    } mem_src_e;

    typedef struct packed {
        mem_src_e   src;
        logic       we;
        logic [1:0] last;   // index of the final byte lane (N-1)
    } mem_txn_t;

    // Width code 2'b11 is served as a full word.
    function automatic logic [1:0] width_last_lane(input logic [1:0] width);
        case (width)
            MemByte: return 2'd0;
            MemHalf: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side request bus of the memory controller: IF fetch channel, MEM load/store channel
// and the per-requester stall requests.
interface mem_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = AddrLen,
    parameter int DATA_W = RegLen
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_inst;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_width;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    logic              if_stall_req;
    logic              mem_stall_req;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata,
        input  if_done, if_inst, mem_done, mem_rdata, if_stall_req, mem_stall_req
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata,
        output if_done, if_inst, mem_done, mem_rdata, if_stall_req, mem_stall_req
    );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serializing memory controller: arbitrates IF fetches and MEM loads/stores onto a
// single-port byte-wide RAM and returns whole little-endian words with a one-cycle done pulse.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = AddrLen,
    parameter int DATA_W = RegLen
) (
    input  logic              clk,
    input  logic              rst,
    mem_ctrl_if.slave         bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state;
    state_e            state_nxt;

    mem_txn_t          txn_q;
    logic [ADDR_W-1:0] base_q;
    logic [1:0]        cnt_q;
    logic [3:0][7:0]   wdata_q;
    logic [3:0][7:0]   stage_q;
    logic [3:0][7:0]   drained;
    logic [DATA_W-1:0] if_inst_q;
    logic [DATA_W-1:0] mem_rdata_q;

    logic              accept;
    logic              cap_en;
    logic [1:0]        cap_lane;
    logic              ret_en;
    logic              done_if;
    logic              done_mem;

    assign accept = (state == S_IDLE) && (bus.mem_req || bus.if_req);

    // ------------------------------------------------------------------ state register
    // NOTE: all clocked state is written with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------ next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.mem_req || bus.if_req) state_nxt = S_ISSUE;
            S_ISSUE: if (cnt_q == txn_q.last) state_nxt = txn_q.we ? S_DONE : S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        ram_addr = '0;
        ram_wr   = 1'b0;
        ram_dout = '0;
        cap_en   = 1'b0;
        cap_lane = 2'd0;
        ret_en   = 1'b0;
        done_if  = 1'b0;
        done_mem = 1'b0;
        case (state)
            S_ISSUE: begin
                ram_addr = base_q + ADDR_W'(cnt_q);
                if (txn_q.we) begin
                    ram_wr   = 1'b1;
                    ram_dout = wdata_q[cnt_q];
                end else if (cnt_q != 2'd0) begin
                    // RAM answers one cycle late, so this cycle's byte belongs to lane k-1.
                    cap_en   = 1'b1;
                    cap_lane = cnt_q - 2'd1;
                end
            end
            S_DRAIN: begin
                cap_en   = 1'b1;
                cap_lane = txn_q.last;
                ret_en   = 1'b1;
            end
            S_DONE: begin
                done_if  = (txn_q.src == SrcIf);
                done_mem = (txn_q.src == SrcMem);
            end
            default: ;
        endcase
    end

    // The final lane arrives during DRAIN; merge it so the word is returned in the DONE cycle.
    always_comb begin
        drained                = stage_q;
        drained[txn_q.last]    = ram_din;
    end

    // ------------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_q       <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            stage_q     <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            if (accept) begin
                // MEM wins a simultaneous arrival; IF keeps its request held and waits.
                if (bus.mem_req) begin
                    txn_q  <= '{src: SrcMem, we: bus.mem_we, last: width_last_lane(bus.mem_width)};
                    base_q <= bus.mem_addr;
                end else begin
                    txn_q  <= '{src: SrcIf, we: 1'b0, last: 2'd3};
                    base_q <= bus.if_addr;
                end
                wdata_q <= bus.mem_wdata[31:0];
                stage_q <= '0;
                cnt_q   <= '0;
            end

            if (state == S_ISSUE) begin
                cnt_q <= cnt_q + 2'd1;
            end

            if (cap_en) begin
                stage_q[cap_lane] <= ram_din;
            end

            if (ret_en) begin
                if (txn_q.src == SrcIf) begin
                    if_inst_q <= drained;
                end else begin
                    mem_rdata_q <= drained;
                end
            end
        end
    end

    // ------------------------------------------------------------------ bus side
    assign bus.if_done       = done_if;
    assign bus.mem_done      = done_mem;
    assign bus.if_inst       = if_inst_q;
    assign bus.mem_rdata     = mem_rdata_q;

    // Combinational so the requester stalls in the very cycle it asks, reset included.
    assign bus.if_stall_req  = bus.if_req  & ~done_if;
    assign bus.mem_stall_req = bus.mem_req & ~done_mem;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller serving the CPU's instruction-fetch and MEM-stage data requests over a single byte-wide, single-port RAM. It is the responder side of the MEM stage's memory request interface. Each request is serialized into little-endian byte accesses, and the completed word is returned with a one-cycle done pulse. It also raises the per-requester stall requests consumed by the stall controller, which produces the `StallLevelLen` stall command seen by the pipeline registers.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: word width; fixed at 4 bytes.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request; held by IF until `if_done`.
- `if_addr` in `ADDR_W`: fetch byte address.
- `if_done` out 1: one-cycle pulse; `if_inst` valid in the same cycle.
- `if_inst` out `DATA_W`: fetched word.
- `mem_req` in 1: data request; held by MEM until `mem_done`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_width` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `mem_addr` in `ADDR_W`: data byte address.
- `mem_wdata` in `DATA_W`: store data; the low bytes are used.
- `mem_done` out 1: one-cycle pulse; `mem_rdata` valid in the same cycle for loads.
- `mem_rdata` out `DATA_W`: load data, zero-extended. MEM performs sign extension.
- `if_stall_req` out 1: IF transaction pending.
- `mem_stall_req` out 1: MEM transaction pending.
- `ram_addr` out `ADDR_W`: RAM byte address.
- `ram_wr` out 1: RAM write strobe.
- `ram_dout` out 8: RAM write byte.
- `ram_din` in 8: RAM read byte; the byte for the address driven in cycle t is valid in cycle t+1.

## Operation
States:
- IDLE
- ISSUE: drives RAM addresses and write data.
- DRAIN: captures the last read byte.
- DONE

Transitions:
- **IDLE → ISSUE:** when either request is high.
  - `mem_req` has priority over `if_req`.
  - The controller latches source, address, `we`, and N bytes. N = 1, 2, or 4; IF is always N = 4 and read.
  - Staged data is cleared.
- **ISSUE:** byte counter k runs 0..N-1.
  - `ram_addr` = base + k, modulo 2^`ADDR_W`. Wrap from 0xFFFFFFFF to 0x0 is legal; no alignment is required.
  - For a store: `ram_wr`=1, `ram_dout` = byte k of `wdata` (bits 8k+7:8k).
  - For a read: `ram_wr`=0, and `ram_din` is captured into byte lane k-1 whenever k ≥ 1.
- **ISSUE → next:** after k = N-1, go to DRAIN if reading, DONE if writing.
- **DRAIN → DONE:** DRAIN captures byte N-1, `ram_wr`=0.
- **DONE:** pulse the done signal of the latched source, with read data on its bus. Next state is IDLE.
  - IDLE does not sample requests during the DONE cycle.
  - Registered requesters see done at the edge and drop `req` before the next IDLE evaluation.

Outputs and stall requests:
- Outside ISSUE: `ram_wr`=0, `ram_addr`=0, `ram_dout`=0.
- `if_inst` and `mem_rdata` hold their last returned value between transactions.
- `if_stall_req` = `if_req` & ~`if_done`. `mem_stall_req` = `mem_req` & ~`mem_done`. Both are combinational, so a stall is raised in the request cycle.
- A request arriving mid-transaction is held by its owner and served after return to IDLE.
- On simultaneous arrival, IF waits behind MEM (starvation bounded by one MEM transaction per pipeline stall).

## Timing
- Request seen in IDLE at cycle A:
  - ISSUE occupies A+1..A+N.
  - Read: DRAIN at A+N+1, done at A+N+2. Latency is 6 cycles for a word, 3 for a byte.
  - Write: done at A+N+1. Latency is 5 cycles for a word, 2 for a byte.
- Minimum gap between one done and the next acceptance: one IDLE cycle.
- Reset values: state IDLE, `if_done`=`mem_done`=0, `if_inst`=`mem_rdata`=0, `ram_*`=0, counter 0.
- Reset mid-transaction:
  - The transaction is abandoned at the next edge, with no done pulse.
  - `ram_wr` is 0 from the cycle after reset is sampled.
  - Partial stores already written stay in RAM.
- Stall requests remain combinational during reset, so a held request keeps its requester stalled until it is served after reset.

## Structure
- Width codes (`MemByte`, `MemHalf`, `MemWord`), `AddrLen`, and `RegLen` go in the shared defines file alongside the existing stall and register constants.
- State encodings are local to the module.
- No sub-module is needed: one FSM, one counter, and a 4-lane byte assembler in a single module.

## Test plan
- **IF word fetch:** RAM[0x100..0x103] = 13,00,50,00; `if_req` at 0x100 → `if_done` 6 cycles after acceptance, `if_inst`=0x00500013, `if_stall_req` high until then.
- **Byte store / half load:** `mem_we`=1, byte, addr 0x2001, `wdata`=0xAABBCCDD → exactly one RAM write of 0xDD at 0x2001, `mem_done` 2 cycles after acceptance. Then a half load at 0x2000 with RAM[0x2000]=0x11 → `mem_rdata`=0x0000DD11.
- **Simultaneous requests:** `if_req` and `mem_req` (word load) in the same cycle → MEM served first; `if_stall_req` stays high; IF is accepted the cycle after `mem_done` + 1 and its `if_done` arrives 6 cycles later.
- **Address wrap:** word store at 0xFFFFFFFE, data 0x04030201 → writes 01@FFFFFFFE, 02@FFFFFFFF, 03@0, 04@1.
- **Reset mid-load:** `rst` asserted at ISSUE k=2 of a word load → no `mem_done` pulse, state IDLE, all outputs 0 next cycle; the still-held `mem_req` restarts a full 6-cycle load after reset deasserts.
- **Back-to-back loads:** MEM keeps `mem_req` through two consecutive loads → exactly one done per transaction and no duplicate acceptance in the DONE cycle.
